// File: rtl/case_6_mul_pipe_sat.sv
// case_6_mul_pipe_sat: pipelined signed/unsigned multiplier with ce stall, valid tracking and truncate/saturate narrowing
module case_6_mul_pipe_sat #(
  parameter int ID = 1,
  parameter int NUM_STAGE = 3,
  parameter int din0_WIDTH = 11,
  parameter int din1_WIDTH = 11,
  parameter int dout_WIDTH = 15,
  parameter int SIGNED = 1,
  parameter int SATURATE = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  din_vld,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  dout_vld,
  output logic                  ovf
);
  localparam int P = din0_WIDTH + din1_WIDTH;
  localparam int W = dout_WIDTH;
  localparam int NP = NUM_STAGE > 2 ? NUM_STAGE - 2 : 1;
  initial
    if (NUM_STAGE < 1 || NUM_STAGE > 6 || din0_WIDTH < 2 || din0_WIDTH > 32 ||
        din1_WIDTH < 2 || din1_WIDTH > 32 || dout_WIDTH < 2 || dout_WIDTH > 64 ||
        SIGNED < 0 || SIGNED > 1 || SATURATE < 0 || SATURATE > 1)
      $fatal(1, "case_6_mul_pipe_sat %0d: illegal parameter set", ID);
  logic [din0_WIDTH-1:0] a;
  logic [din1_WIDTH-1:0] b;
  logic                  av;
  generate
    if (NUM_STAGE == 1) begin : g_bypass
      assign a = din0;
      assign b = din1;
      assign av = din_vld;
    end else begin : g_opreg
      always_ff @(posedge clk or posedge reset)
        if (reset) begin
          a <= '0;
          b <= '0;
          av <= 1'b0;
        end else if (ce) begin
          a <= din0;
          b <= din1;
          av <= din_vld;
        end
    end
  endgenerate
  // Extending both operands to P bits makes the P-bit modular product exact
  logic [P-1:0] ea, eb, prod;
  assign ea = {{din1_WIDTH{SIGNED != 0 && a[din0_WIDTH-1]}}, a};
  assign eb = {{din0_WIDTH{SIGNED != 0 && b[din1_WIDTH-1]}}, b};
  assign prod = ea * eb;
  logic [P-1:0] q;
  logic         qv;
  generate
    if (NUM_STAGE > 2) begin : g_ppipe
      logic [P-1:0]  pp [NP];
      logic [NP-1:0] pv;
      always_ff @(posedge clk or posedge reset)
        if (reset) begin
          for (int i = 0; i < NP; i++) pp[i] <= '0;
          pv <= '0;
        end else if (ce) begin
          pp[0] <= prod;
          pv[0] <= av;
          for (int i = 1; i < NP; i++) begin
            pp[i] <= pp[i-1];
            pv[i] <= pv[i-1];
          end
        end
      assign q = pp[NP-1];
      assign qv = pv[NP-1];
    end else begin : g_nopipe
      assign q = prod;
      assign qv = av;
    end
  endgenerate
  logic [W-1:0] n;
  logic         nov;
  generate
    if (W >= P) begin : g_wide
      always_comb begin
        n = {W{SIGNED != 0 && q[P-1]}};
        n[P-1:0] = q;
      end
      assign nov = 1'b0;
    end else begin : g_narrow
      logic [W-1:0] lim;
      assign nov = SIGNED != 0 ? (|q[P-1:W-1] && !(&q[P-1:W-1])) : |q[P-1:W];
      assign lim = {SIGNED == 0 || q[P-1], {(W-1){SIGNED == 0 || !q[P-1]}}};
      assign n = SATURATE != 0 && nov ? lim : q[W-1:0];
    end
  endgenerate
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      dout <= '0;
      dout_vld <= 1'b0;
      ovf <= 1'b0;
    end else if (ce) begin
      dout <= n;
      dout_vld <= qv;
      ovf <= nov;
    end
endmodule

// File: tb/tb_case_6_mul_pipe_sat.sv
// tb_case_6_mul_pipe_sat: directed checks over default, truncating, unsigned and single-stage builds sharing one stimulus
module tb_case_6_mul_pipe_sat;
  logic clk = 1'b0, reset = 1'b1, ce = 1'b1, din_vld = 1'b0;
  logic [10:0] din0 = '0, din1 = '0;
  logic [14:0] dd, dt, du, d1;
  logic vd, vt, vu, v1, od, ot, ou, o1;
  int n_run = 0, n_fail = 0;
  always #5 clk = ~clk;
  case_6_mul_pipe_sat d_def (.clk(clk), .reset(reset), .ce(ce), .din_vld(din_vld), .din0(din0), .din1(din1), .dout(dd), .dout_vld(vd), .ovf(od));
  case_6_mul_pipe_sat #(.SATURATE(0)) d_trunc (.clk(clk), .reset(reset), .ce(ce), .din_vld(din_vld), .din0(din0), .din1(din1), .dout(dt), .dout_vld(vt), .ovf(ot));
  case_6_mul_pipe_sat #(.SIGNED(0)) d_uns (.clk(clk), .reset(reset), .ce(ce), .din_vld(din_vld), .din0(din0), .din1(din1), .dout(du), .dout_vld(vu), .ovf(ou));
  case_6_mul_pipe_sat #(.NUM_STAGE(1)) d_s1 (.clk(clk), .reset(reset), .ce(ce), .din_vld(din_vld), .din0(din0), .din1(din1), .dout(d1), .dout_vld(v1), .ovf(o1));
  task automatic chk_b(input string tag, input logic got, input logic exp);
    n_run++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask
  task automatic chk_d(input string tag, input logic [14:0] got, input int exp);
    n_run++;
    assert (got === 15'(exp)) else begin
      n_fail++;
      $error("FAIL %s: got %0d (0x%h) expected 0x%h", tag, got, got, 15'(exp));
    end
  endtask
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic drive(input int x, input int y, input logic v);
    din0 = 11'(x);
    din1 = 11'(y);
    din_vld = v;
  endtask
  initial begin
    tick;
    chk_b("rst vld", vd, 1'b0);
    chk_d("rst dout", dd, 0);
    chk_b("rst ovf", od, 1'b0);
    reset = 1'b0;
    // single sample: 3-stage result after third edge, 1-stage after first
    drive(100, -50, 1'b1);
    tick;
    drive(0, 0, 1'b0);
    chk_b("t1 vld early", vd, 1'b0);
    chk_b("t6 s1 vld", v1, 1'b1);
    chk_d("t6 s1 dout", d1, -5000);
    chk_b("t6 s1 ovf", o1, 1'b0);
    tick;
    chk_b("t1 vld before", vd, 1'b0);
    chk_b("t6 s1 vld after", v1, 1'b0);
    tick;
    chk_b("t1 vld", vd, 1'b1);
    chk_d("t1 dout", dd, -5000);
    chk_b("t1 ovf", od, 1'b0);
    tick;
    chk_b("t1 vld after", vd, 1'b0);
    // overflow corners
    drive(-1024, -1024, 1'b1);
    tick;
    drive(-1024, 1023, 1'b1);
    tick;
    drive(0, 0, 1'b0);
    tick;
    chk_b("t2 vld", vd, 1'b1);
    chk_d("t2 sat pos", dd, 16383);
    chk_b("t2 sat pos ovf", od, 1'b1);
    chk_d("t2 trunc", dt, 0);
    chk_b("t2 trunc ovf", ot, 1'b1);
    tick;
    chk_d("t2 sat neg", dd, -16384);
    chk_b("t2 sat neg ovf", od, 1'b1);
    chk_d("t2 trunc neg", dt, 1024);
    chk_b("t2 trunc neg ovf", ot, 1'b1);
    // back-to-back stream
    for (int i = 0; i < 22; i++) begin
      if (i < 20) drive(i, i + 1, 1'b1);
      else drive(0, 0, 1'b0);
      tick;
      if (i < 2) chk_b("t3 bubble", vd, 1'b0);
      else begin
        chk_b("t3 vld", vd, 1'b1);
        chk_d("t3 dout", dd, (i - 2) * (i - 1));
        chk_b("t3 ovf", od, 1'b0);
      end
    end
    tick;
    chk_b("t3 vld end", vd, 1'b0);
    // stall with a result on the output and one sample in flight
    drive(3, 5, 1'b1);
    tick;
    drive(7, 9, 1'b1);
    tick;
    drive(0, 0, 1'b0);
    tick;
    chk_b("t4 pre vld", vd, 1'b1);
    chk_d("t4 pre dout", dd, 15);
    ce = 1'b0;
    drive(2, 2, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick;
      chk_b("t4 frz vld", vd, 1'b1);
      chk_d("t4 frz dout", dd, 15);
      chk_b("t4 frz ovf", od, 1'b0);
    end
    ce = 1'b1;
    drive(0, 0, 1'b0);
    tick;
    chk_b("t4 vld", vd, 1'b1);
    chk_d("t4 dout", dd, 63);
    tick;
    chk_b("t4 vld after", vd, 1'b0);
    // asynchronous reset with samples in flight
    drive(-1024, -1024, 1'b1);
    tick;
    drive(4, 5, 1'b1);
    tick;
    drive(6, 7, 1'b1);
    tick;
    chk_b("t5 pre vld", vd, 1'b1);
    chk_d("t5 pre dout", dd, 16383);
    chk_b("t5 pre ovf", od, 1'b1);
    drive(0, 0, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk_b("t5 async vld", vd, 1'b0);
    chk_d("t5 async dout", dd, 0);
    chk_b("t5 async ovf", od, 1'b0);
    chk_b("t5 async s1 vld", v1, 1'b0);
    tick;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk_b("t5 post vld", vd, 1'b0);
    end
    // unsigned build
    drive(2047, 2047, 1'b1);
    tick;
    drive(100, 300, 1'b1);
    tick;
    drive(0, 0, 1'b0);
    tick;
    chk_b("t6 u vld", vu, 1'b1);
    chk_d("t6 u sat", du, 32767);
    chk_b("t6 u ovf", ou, 1'b1);
    chk_d("t6 s minus1 sq", dd, 1);
    chk_b("t6 s minus1 ovf", od, 1'b0);
    tick;
    chk_d("t6 u dout", du, 30000);
    chk_b("t6 u no ovf", ou, 1'b0);
    chk_d("t6 s sat", dd, 16383);
    chk_b("t6 s ovf", od, 1'b1);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/case_6_mul_pipe_sat.md
Name: case_6_mul_pipe_sat

Overview:
Parametrised, pipelined integer multiplier. It is the multi-cycle successor to the combinational fixed-width multiplier cores used by the generated datapaths. It adds:
- a configurable pipeline depth with clock-enable stall;
- per-sample valid tracking;
- signed or unsigned operand mode;
- a selectable truncate-or-saturate narrowing stage with an overflow flag.

The scheduler instantiates it wherever a multiply is bound to a multi-cycle resource.

Parameters:
ID, 1, instance identifier; no functional effect.
NUM_STAGE, 3, pipeline latency in enabled cycles; legal range 1..6.
din0_WIDTH, 11, width of operand 0; legal range 2..32.
din1_WIDTH, 11, width of operand 1; legal range 2..32.
dout_WIDTH, 15, result width; legal range 2..64.
SIGNED, 1, 1 = both operands two's complement; 0 = both unsigned.
SATURATE, 1, 1 = clamp on overflow; 0 = keep the low dout_WIDTH bits.

Ports:
clk  in  1  clock; all state updates on its rising edge.
reset  in  1  asynchronous, active-high reset.
ce  in  1  clock enable; 0 freezes the entire pipeline.
din_vld  in  1  operands valid this cycle; sampled only when ce=1.
din0  in  din0_WIDTH  operand 0.
din1  in  din1_WIDTH  operand 1.
dout  out  dout_WIDTH  narrowed product.
dout_vld  out  1  dout holds a valid result.
ovf  out  1  the full product did not fit in dout_WIDTH; qualified by dout_vld.

Behaviour:
- Reset:
  - Asserting reset immediately clears every pipeline register, every valid bit, dout, dout_vld and ovf to 0, without waiting for a clock edge.
  - Clearing is independent of ce.
  - In-flight samples are discarded; no stale result appears after reset is released.
- Full product width P = din0_WIDTH + din1_WIDTH. The product is computed exactly at width P, sign-extended when SIGNED=1 and zero-extended when SIGNED=0.
- Pipeline structure:
  - Stage 1 registers din0, din1 and din_vld.
  - Later stages register the P-bit product and its valid bit.
  - The final stage registers the narrowed dout, dout_vld and ovf.
  - With NUM_STAGE=1 a single register stage holds the already-narrowed result.
- Latency and throughput:
  - With ce held at 1, a sample accepted on edge N appears on edge N+NUM_STAGE-1, i.e. it is visible in cycle N+NUM_STAGE.
  - Throughput is one sample per enabled cycle. There is no backpressure other than ce.
- ce=0: all registers, including dout, dout_vld and ovf, hold their values. din_vld and the operands are ignored.
- Bubbles: valid bits travel with the data. Operand registers capture regardless of din_vld (no gating needed), and dout/ovf may change during bubbles. Consumers qualify them with dout_vld.
- Narrowing when dout_WIDTH >= P: sign- or zero-extend; ovf is always 0.
- Narrowing when dout_WIDTH < P:
  - Representable range is [-2^(dout_WIDTH-1), 2^(dout_WIDTH-1)-1] when SIGNED=1, and [0, 2^dout_WIDTH-1] when SIGNED=0.
  - ovf=1 iff the full product lies outside that range, in either SATURATE mode.
  - SATURATE=1: an out-of-range result clamps to the nearest bound (max for positive overflow, min for negative overflow).
  - SATURATE=0: dout = product[dout_WIDTH-1:0].
- Edge operands: the most-negative value times the most-negative value is handled exactly; there is no internal overflow at width P.
- Simultaneous reset and ce: reset wins.
- Parameter checks: out-of-range parameters are a simulation error, raised by an initial-block check that calls $fatal. They are not silently clamped.

Test Plan:
1. Defaults (11x11 signed to 15, NUM_STAGE=3, SATURATE=1), ce=1. Drive din0=100, din1=-50, din_vld=1 for one cycle at edge 0. Require dout_vld=1 exactly 3 cycles later with dout=-5000 (0x6C78) and ovf=0, and dout_vld=0 on the cycles either side.
2. Defaults. Drive din0=-1024, din1=-1024, whose product is 1048576. Require dout=16383 and ovf=1. Rebuild with SATURATE=0 and require dout=0 and ovf=1. Drive din0=-1024, din1=1023 (product -1047552) with SATURATE=1 and require dout=-16384 and ovf=1.
3. Defaults. Stream din0=k, din1=k+1 for k=0..19 on consecutive cycles with ce=1. Require 20 consecutive dout_vld pulses with dout=k*(k+1), which is in range through k=19 (max 380), and ovf=0.
4. Stall. Issue din0=7, din1=9 at edge 0 and hold ce=0 for cycles 1-2. Require the result 63 to appear at cycle 5, and require dout, dout_vld and ovf to stay frozen during the stall cycles.
5. Reset mid-flight. With two samples in flight, assert reset asynchronously between edges. Require dout_vld, dout and ovf to read 0 before the next edge, and dout_vld to stay 0 for NUM_STAGE cycles after release unless new inputs are issued.
6. SIGNED=0, SATURATE=1, 11x11 to 15. Drive din0=2047, din1=2047 (product 4190209) and require dout=32767, ovf=1. Drive din0=100, din1=300 and require dout=30000, ovf=0. Repeat test 1 with NUM_STAGE=1 and require the result 1 cycle after issue.
